// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, type-field placement, default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package noc_pkg;

    // Default flit width (bits, including the type field) and downstream buffer depth.
    localparam int NOC_DATA_WIDTH = 16;
    localparam int NOC_DEPTH      = 5;

    // The flit type occupies the top FLIT_TYPE_BITS bits of every flit.
    localparam int FLIT_TYPE_BITS = 2;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Wormhole tracking state of an output port.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } port_state_e;

endpackage

// File: rtl/credit_counter.sv
// Credit counter for a downstream buffer: +1 per returned credit, -1 per sent flit.
// Latency: count updates one cycle after inc/dec; overflow is combinational from inc/dec/count.
// Backpressure: none itself; the caller must not assert dec while count is zero.
//
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset (count <= DEPTH)
//   inc         : one credit returned this cycle
//   dec         : one credit consumed this cycle
//   count       : current credit count
//   overflow    : credit returned while already full (count held at DEPTH)
module credit_counter #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // A credit returned while consuming one is a net zero change, so it can never overflow.
    assign overflow = inc && !dec && (count == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= FULL;
        end else if (inc && !dec) begin
            if (count != FULL) begin
                count <= count + ONE;
            end
        end else if (dec && !inc) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/noc_output_port.sv
// Router output port: wormhole-checks flits from the crossbar and writes legal ones downstream.
// Latency: 1 cycle from accept to op_write_o/op_data_o; illegal flits are dropped.
// Backpressure: op_ready_o low when no downstream credits remain; credits return via op_credit_i.
//
// Ports:
//   clk, reset               : rising-edge clock, synchronous active-high reset
//   op_data_i / op_valid_i   : flit offered by the crossbar and its qualifier
//   op_ready_o               : flit can be accepted this cycle (credits != 0, registered state only)
//   op_credit_i              : one-cycle pulse, one downstream slot freed
//   op_data_o / op_write_o   : registered flit and write strobe to the downstream buffer
//   op_credits_o             : current credit count
//   op_busy_o                : wormhole packet in progress
//   op_err_o                 : sticky protocol error (illegal flit or credit overflow)
module noc_output_port
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH   = NOC_DATA_WIDTH,
    parameter int DEPTH        = NOC_DEPTH,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   op_data_i,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic                    op_credit_i,
    output logic [DATA_WIDTH-1:0]   op_data_o,
    output logic                    op_write_o,
    output logic [CREDIT_WIDTH-1:0] op_credits_o,
    output logic                    op_busy_o,
    output logic                    op_err_o
);

    port_state_e state_q;
    port_state_e state_d;
    flit_type_e  flit_type;
    logic        accept;
    logic        fwd;
    logic        illegal;
    logic        overflow;

    assign flit_type  = flit_type_e'(op_data_i[DATA_WIDTH-1 -: FLIT_TYPE_BITS]);
    assign op_ready_o = (op_credits_o != '0);
    assign accept     = op_valid_i && op_ready_o;
    assign op_busy_o  = (state_q == ST_PKT);

    // Wormhole legality: a packet opens with HEAD and closes with TAIL; SINGLE stands alone.
    // An illegal flit is consumed from the crossbar but neither written nor charged a credit.
    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        illegal = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    case (flit_type)
                        FLIT_HEAD: begin
                            fwd     = 1'b1;
                            state_d = ST_PKT;
                        end
                        FLIT_SINGLE: fwd     = 1'b1;
                        default:     illegal = 1'b1;
                    endcase
                end
                ST_PKT: begin
                    case (flit_type)
                        FLIT_BODY: fwd = 1'b1;
                        FLIT_TAIL: begin
                            fwd     = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: illegal = 1'b1;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_write_o <= 1'b0;
            op_data_o  <= '0;
            op_err_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_o <= fwd;
            if (fwd) begin
                op_data_o <= op_data_i;
            end
            if (illegal || overflow) begin
                op_err_o <= 1'b1;
            end
        end
    end

    // fwd already requires credits != 0, so the counter never underflows.
    credit_counter #(
        .DEPTH (DEPTH),
        .WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (op_credit_i),
        .dec      (fwd),
        .count    (op_credits_o),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_noc_output_port.sv
// Bench for noc_output_port: directed scenarios plus random traffic against a packet-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_noc_output_port;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] op_data_i;
    logic          op_valid_i;
    logic          op_ready_o;
    logic          op_credit_i;
    logic [DW-1:0] op_data_o;
    logic          op_write_o;
    logic [CW-1:0] op_credits_o;
    logic          op_busy_o;
    logic          op_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int          m_credits;
    bit          m_in_pkt;
    bit          m_err;
    bit          m_write;
    logic [15:0] m_data;

    noc_output_port #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .CREDIT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_data_i    (op_data_i),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_credit_i  (op_credit_i),
        .op_data_o    (op_data_o),
        .op_write_o   (op_write_o),
        .op_credits_o (op_credits_o),
        .op_busy_o    (op_busy_o),
        .op_err_o     (op_err_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model by the packet rules, step past the edge.
    task automatic cyc(input bit v, input logic [15:0] d, input bit c, input bit r);
        bit          ready, acc, legal, fwd;
        logic [1:0]  t;
        reset       = r;
        op_valid_i  = v;
        op_data_i   = d;
        op_credit_i = c;
        if (r) begin
            m_credits = DEPTH;
            m_in_pkt  = 0;
            m_err     = 0;
            m_write   = 0;
            m_data    = '0;
        end else begin
            t     = d[15:14];
            ready = (m_credits > 0);
            acc   = v && ready;
            // Inside a packet only BODY/TAIL continue it; outside only HEAD/SINGLE may start.
            legal = m_in_pkt ? (t == 2'b00 || t == 2'b10) : (t == 2'b01 || t == 2'b11);
            fwd   = acc && legal;
            if (acc && !legal) m_err = 1;
            if (fwd) begin
                m_data = d;
                if (t == 2'b01) m_in_pkt = 1;
                if (t == 2'b10) m_in_pkt = 0;
            end
            m_write = fwd;
            if (c && !fwd && m_credits == DEPTH) m_err = 1;
            else m_credits = m_credits + (c ? 1 : 0) - (fwd ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 16'hC0DE, 1, 1);
        cyc(1, 16'hC0DE, 1, 1);
        n_checks++; if (op_credits_o !== 3'd5) begin n_fail++; $display("FAIL reset_credits got=%0d want=5", op_credits_o); end
        n_checks++; if (op_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b want=0", op_write_o); end
        n_checks++; if (op_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h want=0000", op_data_o); end
        n_checks++; if (op_err_o !== 1'b0 || op_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_err_busy got=%b%b want=00", op_err_o, op_busy_o); end
        n_checks++; if (op_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", op_ready_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'hC001 + 16'(i), 0, 0);
            n_checks++; if (op_write_o !== 1'b1 || op_data_o !== 16'hC001 + 16'(i)) begin
                n_fail++; $display("FAIL b2b_write[%0d] got=%b/%h want=1/%h", i, op_write_o, op_data_o, 16'hC001 + 16'(i)); end
            n_checks++; if (op_credits_o !== 3'(4 - i)) begin
                n_fail++; $display("FAIL b2b_credits[%0d] got=%0d want=%0d", i, op_credits_o, 4 - i); end
        end
        n_checks++; if (op_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low got=%b want=0", op_ready_o); end
    endtask

    task automatic test_credit_return();
        cyc(1, 16'hC006, 0, 0);
        n_checks++; if (op_write_o !== 1'b0 || op_credits_o !== 3'd0) begin
            n_fail++; $display("FAIL stall got=%b/%0d want=0/0", op_write_o, op_credits_o); end
        cyc(1, 16'hC006, 1, 0);
        n_checks++; if (op_ready_o !== 1'b1 || op_write_o !== 1'b0) begin
            n_fail++; $display("FAIL credit_ready got=%b/%b want=1/0", op_ready_o, op_write_o); end
        cyc(1, 16'hC006, 0, 0);
        n_checks++; if (op_write_o !== 1'b1 || op_data_o !== 16'hC006 || op_credits_o !== 3'd0) begin
            n_fail++; $display("FAIL credit_accept got=%b/%h/%0d want=1/c006/0", op_write_o, op_data_o, op_credits_o); end
        cyc(0, 16'hFFFF, 0, 0);
        n_checks++; if (op_write_o !== 1'b0 || op_data_o !== 16'hC006) begin
            n_fail++; $display("FAIL data_hold got=%b/%h want=0/c006", op_write_o, op_data_o); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 0);
        n_checks++; if (op_credits_o !== 3'd3) begin n_fail++; $display("FAIL refill got=%0d want=3", op_credits_o); end
        cyc(1, 16'hC007, 1, 0);
        n_checks++; if (op_credits_o !== 3'd3 || op_write_o !== 1'b1 || op_data_o !== 16'hC007) begin
            n_fail++; $display("FAIL simul got=%0d/%b/%h want=3/1/c007", op_credits_o, op_write_o, op_data_o); end
    endtask

    task automatic test_wormhole();
        cyc(1, 16'h4000, 0, 0);
        n_checks++; if (op_write_o !== 1'b1 || op_busy_o !== 1'b1 || op_credits_o !== 3'd2) begin
            n_fail++; $display("FAIL head got=%b/%b/%0d want=1/1/2", op_write_o, op_busy_o, op_credits_o); end
        cyc(1, 16'h0011, 1, 0);
        n_checks++; if (op_write_o !== 1'b1 || op_data_o !== 16'h0011 || op_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL body got=%b/%h/%b want=1/0011/1", op_write_o, op_data_o, op_busy_o); end
        cyc(1, 16'h8022, 1, 0);
        n_checks++; if (op_write_o !== 1'b1 || op_data_o !== 16'h8022 || op_busy_o !== 1'b0 || op_credits_o !== 3'd2) begin
            n_fail++; $display("FAIL tail got=%b/%h/%b/%0d want=1/8022/0/2", op_write_o, op_data_o, op_busy_o, op_credits_o); end
        cyc(0, 16'h0, 0, 0);
        n_checks++; if (op_write_o !== 1'b0 || op_err_o !== 1'b0) begin
            n_fail++; $display("FAIL after_tail got=%b/%b want=0/0", op_write_o, op_err_o); end
    endtask

    task automatic test_illegal();
        cyc(1, 16'h0033, 0, 0);
        n_checks++; if (op_write_o !== 1'b0 || op_credits_o !== 3'd2 || op_err_o !== 1'b1 || op_busy_o !== 1'b0) begin
            n_fail++; $display("FAIL body_idle got=%b/%0d/%b/%b want=0/2/1/0", op_write_o, op_credits_o, op_err_o, op_busy_o); end
        cyc(0, 16'h0, 0, 0);
        cyc(0, 16'h0, 0, 0);
        n_checks++; if (op_err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b want=1", op_err_o); end
        cyc(1, 16'h4100, 0, 0);
        cyc(1, 16'h4200, 0, 0);
        n_checks++; if (op_write_o !== 1'b0 || op_busy_o !== 1'b1 || op_credits_o !== 3'd1 || op_data_o !== 16'h4100) begin
            n_fail++; $display("FAIL head_in_pkt got=%b/%b/%0d/%h want=0/1/1/4100", op_write_o, op_busy_o, op_credits_o, op_data_o); end
        cyc(1, 16'h8033, 0, 0);
        n_checks++; if (op_write_o !== 1'b1 || op_busy_o !== 1'b0 || op_credits_o !== 3'd0) begin
            n_fail++; $display("FAIL close_pkt got=%b/%b/%0d want=1/0/0", op_write_o, op_busy_o, op_credits_o); end
    endtask

    task automatic test_overflow_and_reset();
        cyc(0, 16'h0, 0, 1);
        cyc(0, 16'h0, 1, 0);
        n_checks++; if (op_credits_o !== 3'd5 || op_err_o !== 1'b1) begin
            n_fail++; $display("FAIL overflow got=%0d/%b want=5/1", op_credits_o, op_err_o); end
        cyc(1, 16'h4000, 0, 0);
        n_checks++; if (op_busy_o !== 1'b1 || op_credits_o !== 3'd4) begin
            n_fail++; $display("FAIL pre_reset_pkt got=%b/%0d want=1/4", op_busy_o, op_credits_o); end
        cyc(1, 16'h0055, 1, 1);
        n_checks++; if (op_busy_o !== 1'b0 || op_credits_o !== 3'd5 || op_err_o !== 1'b0 || op_write_o !== 1'b0 || op_data_o !== 16'h0) begin
            n_fail++; $display("FAIL mid_pkt_reset got=%b/%0d/%b/%b/%h want=0/5/0/0/0000", op_busy_o, op_credits_o, op_err_o, op_write_o, op_data_o); end
        cyc(1, 16'h0044, 0, 0);
        n_checks++; if (op_write_o !== 1'b0 || op_err_o !== 1'b1) begin
            n_fail++; $display("FAIL body_after_reset got=%b/%b want=0/1", op_write_o, op_err_o); end
        cyc(0, 16'h0, 0, 1);
    endtask

    task automatic test_random();
        bit          v, c, r;
        logic [15:0] d;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            d = 16'($urandom);
            c = ($urandom_range(0, 3) == 0) && (m_credits < DEPTH || $urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 99) < 2);
            cyc(v, d, c, r);
            n_checks++;
            if (op_write_o !== m_write || op_data_o !== m_data || op_credits_o !== 3'(m_credits) ||
                op_busy_o !== m_in_pkt || op_err_o !== m_err || op_ready_o !== (m_credits != 0)) begin
                n_fail++;
                $display("FAIL rand[%0d] got w=%b d=%h cr=%0d b=%b e=%b rdy=%b want w=%b d=%h cr=%0d b=%b e=%b",
                         i, op_write_o, op_data_o, op_credits_o, op_busy_o, op_err_o, op_ready_o,
                         m_write, m_data, m_credits, m_in_pkt, m_err);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        op_valid_i  = 1'b0;
        op_data_i   = '0;
        op_credit_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_credit_return();
        test_simultaneous();
        test_wormhole();
        test_illegal();
        test_overflow_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_output_port.md
NOC_OUTPUT_PORT -- requirements
Module: noc_output_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning flit width in bits including the 2-bit type field in [DATA_WIDTH-1:DATA_WIDTH-2].
REQ-002 SHALL have parameter DEPTH, default 5, meaning downstream input-buffer depth, which is also the initial credit count.
REQ-003 SHALL have parameter CREDIT_WIDTH, default 3, meaning credit counter width; it must hold DEPTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port op_data_i, input, DATA_WIDTH, flit offered by the crossbar.
REQ-007 SHALL have port op_valid_i, input, 1, flit-offered qualifier.
REQ-008 SHALL have port op_ready_o, output, 1, asserted when the port can accept a flit this cycle.
REQ-009 SHALL have port op_credit_i, input, 1, one-cycle pulse meaning one downstream slot was freed (downstream read).
REQ-010 SHALL have port op_data_o, output, DATA_WIDTH, flit to the downstream buffer write-data input.
REQ-011 SHALL have port op_write_o, output, 1, downstream buffer write strobe.
REQ-012 SHALL have port op_credits_o, output, CREDIT_WIDTH, current credit count.
REQ-013 SHALL have port op_busy_o, output, 1, wormhole packet in progress.
REQ-014 SHALL have port op_err_o, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL decode flit type as 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail).
REQ-016 SHALL drive op_ready_o = (credits != 0), from registered state only; it never depends combinationally on op_credit_i.
REQ-017 SHALL accept a flit when op_valid_i && op_ready_o.
REQ-018 SHALL forward an accepted legal flit with 1-cycle latency: op_data_o is registered and op_write_o is high for exactly that next cycle.
REQ-019 SHALL hold op_data_o at its last value and drive op_write_o low in cycles with no forwarded flit.
REQ-020 SHALL decrement credits per forwarded flit and increment per op_credit_i pulse; when both occur in the same cycle, credits are unchanged.
REQ-021 SHALL, on op_credit_i while credits == DEPTH with no simultaneous forward, hold credits at DEPTH and set op_err_o.
REQ-022 SHALL implement FSM states IDLE and PKT; op_busy_o = (state == PKT).
REQ-023 SHALL, in IDLE: HEAD -> PKT; SINGLE is forwarded and stays IDLE; BODY or TAIL is illegal.
REQ-024 SHALL, in PKT: BODY is forwarded and stays PKT; TAIL is forwarded -> IDLE; HEAD or SINGLE is illegal.
REQ-025 SHALL, for an illegal accepted flit: drop it (no write, no credit consumed), set op_err_o, and leave the FSM state unchanged.
REQ-026 SHALL hold op_err_o high until reset once it is set.

Reset
REQ-027 SHALL, while reset is high at a clock edge: credits = DEPTH, state = IDLE, op_write_o = 0, op_data_o = 0, op_err_o = 0.
REQ-028 SHALL drop an in-flight packet on reset mid-packet; the first flit accepted after reset is evaluated in IDLE.
REQ-029 SHALL ignore op_valid_i and op_credit_i in any cycle where reset is high.

Structure
REQ-030 SHALL place the flit-type enum, the type-field position, and default DATA_WIDTH/DEPTH constants in shared package noc_pkg, also used by the router input side.
REQ-031 SHALL implement the credit logic as sub-module credit_counter (inc, dec, count, overflow), instantiated once.

Verification
REQ-032 SHALL verify: reset, then DEPTH=5 back-to-back valid SINGLE flits 0xC001..0xC005 -> five writes in cycles 2..6, credits 5->0, op_ready_o low after the 5th accept.
REQ-033 SHALL verify: at credits=0 with valid held, pulse op_credit_i once -> op_ready_o high next cycle, one flit accepted and written, credits return to 0.
REQ-034 SHALL verify: simultaneous accept and op_credit_i at credits=3 -> credits stay 3 and the flit is written.
REQ-035 SHALL verify: HEAD 0x4000, BODY 0x0011, TAIL 0x8022 -> op_busy_o high from the cycle after HEAD through the TAIL accept, low after; three writes.
REQ-036 SHALL verify: BODY 0x0033 in IDLE -> no write, credits unchanged, op_err_o = 1 and sticky; then HEAD during PKT -> dropped, state stays PKT.
REQ-037 SHALL verify: op_credit_i at credits=5 -> credits stay 5, op_err_o = 1; reset mid-packet -> IDLE, credits 5, op_err_o 0.
